// File: rtl/fpu_op_sequencer_pkg.sv
// Shared FPU word layout, status bit indices and sequencer state encoding.
package fpu_op_sequencer_pkg;
  localparam int EXP_WIDTH      = 11;
  localparam int MANTISSA_WIDTH = 20;
  localparam int SIGN_BIT       = 31;
  localparam int EXP_MSB        = 30;
  localparam int EXP_LSB        = 20;
  localparam int MAN_MSB        = 19;

  localparam int ST_EXACT   = 3;
  localparam int ST_OVF     = 2;
  localparam int ST_UNF     = 1;
  localparam int ST_INEXACT = 0;

  localparam logic [3:0] BYPASS_STATUS = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Sign is ignored: both +0 and -0 count as zero.
  function automatic logic is_zero(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == '0) && (v[MAN_MSB:0] == '0);
  endfunction
endpackage

// File: rtl/fpu_operand_classify.sv
// Zero detect on an operand pair and the result to return when the FPU is skipped.
module fpu_operand_classify
  import fpu_op_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        bypass,
  output logic [31:0] bypass_data
);
  logic a_zero, b_zero;

  always_comb begin
    a_zero      = is_zero(a);
    b_zero      = is_zero(b);
    bypass      = a_zero | b_zero;
    bypass_data = a;
    if (a_zero && b_zero)
      bypass_data = {a[SIGN_BIT] & b[SIGN_BIT], 31'b0};
    else if (a_zero)
      bypass_data = b;
  end
endmodule

// File: rtl/fpu_op_sequencer.sv
// Issue/return sequencer for the fixed-latency FPU adder: holds operands for
// LATENCY edges, captures the result, returns it, keeps sticky flags and op count.
module fpu_op_sequencer
  import fpu_op_sequencer_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  input  logic [31:0]      fpu_data,
  input  logic [3:0]       fpu_status,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_status,
  input  logic             clear_sticky,
  output logic [2:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);
  localparam int LCNT_W = $clog2(LATENCY);

  state_t              state;
  logic [LCNT_W-1:0]   cnt;
  logic                bypass;
  logic [31:0]         bypass_data;
  logic                deliver;

  fpu_operand_classify u_classify (
    .a           (in_a),
    .b           (in_b),
    .bypass      (bypass),
    .bypass_data (bypass_data)
  );

  assign in_ready = (state == S_IDLE);
  assign deliver  = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      fpu_op_a     <= '0;
      fpu_op_b     <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_status   <= '0;
      sticky_flags <= '0;
      op_count     <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          if (bypass) begin
            res_data   <= bypass_data;
            res_status <= BYPASS_STATUS;
            res_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            fpu_op_a <= in_a;
            fpu_op_b <= in_b;
            cnt      <= LCNT_W'(LATENCY - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Sample on the LATENCY-th edge after the operands were loaded.
          if (cnt == '0) begin
            res_data   <= fpu_data;
            res_status <= fpu_status;
            res_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A clear that lands on a delivery still keeps that delivery's flags.
      if (deliver) begin
        sticky_flags <= (clear_sticky ? 3'b000 : sticky_flags) |
                        {res_status[ST_OVF], res_status[ST_UNF], res_status[ST_INEXACT]};
        op_count     <= op_count + 1'b1;
      end else if (clear_sticky) begin
        sticky_flags <= 3'b000;
      end
    end
  end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a transaction-level reference model
// and a stub FPU whose output is only meaningful on the correct sample cycle.
module tb_fpu_op_sequencer;
  localparam int LAT = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [31:0]   in_a = '0, in_b = '0;
  logic [31:0]   fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]    fpu_status;
  logic          res_valid, res_ready = 1'b0;
  logic [31:0]   res_data;
  logic [3:0]    res_status;
  logic          clear_sticky = 1'b0;
  logic [2:0]    sticky_flags;
  logic [CW-1:0] op_count;

  int pass_cnt = 0, total_cnt = 0;
  bit run_cmp = 1'b0;

  fpu_op_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_data(fpu_data), .fpu_status(fpu_status), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_status(res_status),
    .clear_sticky(clear_sticky), .sticky_flags(sticky_flags), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stub FPU: result is valid only in the cycle just before the LATENCY-th edge after accept.
  logic [31:0] stub_data   = 32'h0;
  logic [3:0]  stub_status = 4'h0;
  int age;
  always @(posedge clk or negedge rst)
    if (!rst)                       age <= 100;
    else if (in_valid && in_ready)  age <= 0;
    else if (age < 100)             age <= age + 1;
  assign fpu_data   = (age == LAT - 1) ? stub_data   : 32'hBAD0BAD0;
  assign fpu_status = (age == LAT - 1) ? stub_status : 4'b1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one outstanding transaction, ready at a cycle timestamp.
  bit          m_pending;
  longint      m_cyc, m_ready_at;
  logic [31:0] m_data, m_opa, m_opb;
  logic [3:0]  m_status;
  logic [2:0]  m_sticky;
  int          m_count;

  always @(posedge clk or negedge rst) begin
    bit hs, acc, az, bz;
    if (!rst) begin
      m_pending = 0; m_cyc = 0; m_ready_at = 0; m_data = 0; m_opa = 0; m_opb = 0;
      m_status = 0; m_sticky = 0; m_count = 0;
    end else begin
      hs  = m_pending && (m_cyc >= m_ready_at) && res_ready;
      acc = !m_pending && in_valid;
      m_cyc++;
      if (hs) begin
        m_pending = 0;
        m_sticky  = (clear_sticky ? 3'b000 : m_sticky) | m_status[2:0];
        m_count   = (m_count + 1) % (1 << CW);
      end else if (clear_sticky) begin
        m_sticky = 3'b000;
      end
      if (acc) begin
        az = (in_a & 32'h7FFF_FFFF) == 0;
        bz = (in_b & 32'h7FFF_FFFF) == 0;
        m_pending = 1;
        if (az || bz) begin
          m_status   = 4'b1000;
          m_data     = (az && bz) ? ((in_a[31] && in_b[31]) ? 32'h8000_0000 : 32'h0)
                                  : (az ? in_b : in_a);
          m_ready_at = m_cyc;
        end else begin
          m_opa = in_a; m_opb = in_b;
          m_data = stub_data; m_status = stub_status;
          m_ready_at = m_cyc + LAT;
        end
      end
    end
  end

  always @(negedge clk) if (run_cmp) begin
    bit ev;
    ev = m_pending && (m_cyc >= m_ready_at);
    check("in_ready", {31'b0, in_ready}, {31'b0, !m_pending});
    check("res_valid", {31'b0, res_valid}, {31'b0, ev});
    if (ev) begin
      check("res_data", res_data, m_data);
      check("res_status", {28'b0, res_status}, {28'b0, m_status});
    end
    check("fpu_op_a", fpu_op_a, m_opa);
    check("fpu_op_b", fpu_op_b, m_opb);
    check("sticky", {29'b0, sticky_flags}, {29'b0, m_sticky});
    check("op_count", {{(32-CW){1'b0}}, op_count}, 32'(m_count));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    if (!res_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    send(a, b); wait_valid(); handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_fpu_op_a", fpu_op_a, 32'h0);
    check("rst_op_count", {{(32-CW){1'b0}}, op_count}, 32'd0);
    rst = 1'b1;
    run_cmp = 1'b1;
    tick();

    // 1: 1.0 + 1.0 through the FPU, exact latency
    stub_data = 32'h4000_0000; stub_status = 4'b1000;
    send(32'h3FF0_0000, 32'h3FF0_0000);
    repeat (LAT - 1) tick();
    check("t1_valid_early", {31'b0, res_valid}, 32'd0);
    tick();
    check("t1_valid", {31'b0, res_valid}, 32'd1);
    check("t1_data", res_data, 32'h4000_0000);
    check("t1_status", {28'b0, res_status}, 32'h8);
    handshake();
    check("t1_count", {{(32-CW){1'b0}}, op_count}, 32'd1);

    // 2: zero bypass, including signed-zero pairs
    send(32'h0000_0000, 32'hBFF0_0000);
    check("t2_valid", {31'b0, res_valid}, 32'd1);
    check("t2_data", res_data, 32'hBFF0_0000);
    check("t2_status", {28'b0, res_status}, 32'h8);
    check("t2_op_a_kept", fpu_op_a, 32'h3FF0_0000);
    handshake();
    send(32'h8000_0000, 32'h8000_0000);
    check("t2_negzero", res_data, 32'h8000_0000);
    handshake();
    send(32'h8000_0000, 32'h0000_0000);
    check("t2_mixzero", res_data, 32'h0000_0000);
    handshake();
    check("t2_count", {{(32-CW){1'b0}}, op_count}, 32'd4);

    // 3: sticky accumulation and clear-with-handshake
    stub_data = 32'h3FF8_0000; stub_status = 4'b0101;
    do_op(32'h3FF0_0000, 32'h3FE0_0000);
    check("t3_sticky1", {29'b0, sticky_flags}, 32'b101);
    stub_status = 4'b0011;
    do_op(32'h3FF0_0000, 32'h3FE0_0000);
    check("t3_sticky2", {29'b0, sticky_flags}, 32'b111);
    stub_status = 4'b0001;
    send(32'h3FF0_0000, 32'h3FE0_0000);
    wait_valid();
    clear_sticky = 1'b1; res_ready = 1'b1;
    tick();
    clear_sticky = 1'b0; res_ready = 1'b0;
    check("t3_sticky3", {29'b0, sticky_flags}, 32'b001);
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    check("t3_clear", {29'b0, sticky_flags}, 32'b000);

    // 4: backpressure for 10 cycles with ignored in_valid pulses
    stub_data = 32'h4008_0000; stub_status = 4'b0001;
    send(32'h4000_0000, 32'h3FF0_0000);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_a = 32'h4010_0000; in_b = 32'h0;
      tick();
    end
    in_valid = 1'b0;
    check("t4_valid", {31'b0, res_valid}, 32'd1);
    check("t4_data", res_data, 32'h4008_0000);
    check("t4_in_ready", {31'b0, in_ready}, 32'd0);
    check("t4_count", {{(32-CW){1'b0}}, op_count}, 32'd7);
    handshake();
    check("t4_count_after", {{(32-CW){1'b0}}, op_count}, 32'd8);

    // 5: async reset during WAIT
    send(32'h4000_0000, 32'h4000_0000);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t5_res_valid", {31'b0, res_valid}, 32'd0);
    check("t5_res_data", res_data, 32'h0);
    check("t5_fpu_op_a", fpu_op_a, 32'h0);
    check("t5_sticky", {29'b0, sticky_flags}, 32'd0);
    check("t5_count", {{(32-CW){1'b0}}, op_count}, 32'd0);
    check("t5_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (LAT + 3) tick();
    check("t5_no_stray", {31'b0, res_valid}, 32'd0);

    // 6: op_count wrap via bypass ops
    res_ready = 1'b1;
    for (int i = 0; i < (1 << CW) - 1; i++) send(32'h0, 32'h3FF0_0000);
    tick();
    check("t6_all_ones", {{(32-CW){1'b0}}, op_count}, 32'((1 << CW) - 1));
    send(32'h0, 32'h3FF0_0000);
    tick();
    check("t6_wrap", {{(32-CW){1'b0}}, op_count}, 32'd0);
    res_ready = 1'b0;
    tick();

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
